// File: rtl/adam_axil_apb_bridge.sv
// adam_axil_apb_bridge: single-outstanding AXI-Lite slave to APB4 master
// with SLVERR mapping, ACCESS timeout and pause/ack quiescing.
module adam_axil_apb_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_pause_req,
  output logic                  o_pause_ack,
  input  logic [ADDR_WIDTH-1:0] i_aw_addr,
  input  logic [2:0]            i_aw_prot,
  input  logic                  i_aw_valid,
  output logic                  o_aw_ready,
  input  logic [DATA_WIDTH-1:0] i_w_data,
  input  logic [STRB_WIDTH-1:0] i_w_strb,
  input  logic                  i_w_valid,
  output logic                  o_w_ready,
  output logic [1:0]            o_b_resp,
  output logic                  o_b_valid,
  input  logic                  i_b_ready,
  input  logic [ADDR_WIDTH-1:0] i_ar_addr,
  input  logic [2:0]            i_ar_prot,
  input  logic                  i_ar_valid,
  output logic                  o_ar_ready,
  output logic [DATA_WIDTH-1:0] o_r_data,
  output logic [1:0]            o_r_resp,
  output logic                  o_r_valid,
  input  logic                  i_r_ready,
  output logic [ADDR_WIDTH-1:0] o_paddr,
  output logic                  o_psel,
  output logic                  o_penable,
  output logic                  o_pwrite,
  output logic [DATA_WIDTH-1:0] o_pwdata,
  output logic [STRB_WIDTH-1:0] o_pstrb,
  output logic [2:0]            o_pprot,
  input  logic [DATA_WIDTH-1:0] i_prdata,
  input  logic                  i_pready,
  input  logic                  i_pslverr
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP,
    S_PAUSED
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_prio_wr;
  logic                  r_write;
  logic                  r_err;
  logic [CW-1:0]         r_cnt;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [STRB_WIDTH-1:0] r_pstrb;
  logic [2:0]            r_pprot;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_wr_cand;
  logic                  w_rd_cand;
  logic                  w_take_wr;
  logic                  w_take_rd;
  logic                  w_timeout;

  assign w_wr_cand = i_aw_valid && i_w_valid;
  assign w_rd_cand = i_ar_valid;
  assign w_timeout = (TIMEOUT != 0) && !i_pready && (r_cnt == TO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_take_wr   = 1'b0;
    w_take_rd   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_pause_req) begin
          w_state_nxt = S_PAUSED;
        end else begin
          w_take_wr = w_wr_cand && (!w_rd_cand || r_prio_wr);
          w_take_rd = w_rd_cand && !w_take_wr;
          if (w_take_wr || w_take_rd) w_state_nxt = S_SETUP;
        end
      end
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: if (i_pready || w_timeout) w_state_nxt = S_RESP;
      S_RESP:   if (r_write ? i_b_ready : i_r_ready) w_state_nxt = S_IDLE;
      S_PAUSED: if (!i_pause_req) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_prio_wr <= 1'b1;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_pprot   <= '0;
      r_rdata   <= '0;
    end else begin
      r_state <= w_state_nxt;
      // priority only alternates when both sides compete
      if ((w_take_wr || w_take_rd) && w_wr_cand && w_rd_cand)
        r_prio_wr <= ~r_prio_wr;
      if (w_take_wr) begin
        r_write  <= 1'b1;
        r_paddr  <= i_aw_addr;
        r_pprot  <= i_aw_prot;
        r_pwdata <= i_w_data;
        r_pstrb  <= i_w_strb;
      end else if (w_take_rd) begin
        r_write <= 1'b0;
        r_paddr <= i_ar_addr;
        r_pprot <= i_ar_prot;
      end
      if (r_state == S_ACCESS) begin
        if (i_pready) begin
          r_cnt <= '0;
          r_err <= i_pslverr;
          if (!r_write) r_rdata <= i_prdata;
        end else if (w_timeout) begin
          r_cnt <= '0;
          r_err <= 1'b1;
          if (!r_write) r_rdata <= '0;
        end else if (TIMEOUT != 0) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_aw_ready  = w_take_wr;
  assign o_w_ready   = w_take_wr;
  assign o_ar_ready  = w_take_rd;
  assign o_pause_ack = (r_state == S_PAUSED);
  assign o_psel      = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign o_penable   = (r_state == S_ACCESS);
  assign o_pwrite    = r_write;
  assign o_paddr     = r_paddr;
  assign o_pwdata    = r_pwdata;
  assign o_pstrb     = r_write ? r_pstrb : '0;
  assign o_pprot     = r_pprot;
  assign o_b_valid   = (r_state == S_RESP) && r_write;
  assign o_r_valid   = (r_state == S_RESP) && !r_write;
  assign o_b_resp    = {r_err, 1'b0};
  assign o_r_resp    = {r_err, 1'b0};
  assign o_r_data    = r_rdata;

endmodule

// File: tb/tb_adam_axil_apb_bridge.sv
// tb_adam_axil_apb_bridge: directed plus randomized transactions
// checked against a transaction-level model of the bridge.
module tb_adam_axil_apb_bridge;

  localparam int TO = 8;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  prot;
  } req_t;

  logic        i_clk;
  logic        i_rst;
  logic        i_pause_req;
  logic        o_pause_ack;
  logic [31:0] i_aw_addr;
  logic [2:0]  i_aw_prot;
  logic        i_aw_valid;
  logic        o_aw_ready;
  logic [31:0] i_w_data;
  logic [3:0]  i_w_strb;
  logic        i_w_valid;
  logic        o_w_ready;
  logic [1:0]  o_b_resp;
  logic        o_b_valid;
  logic        i_b_ready;
  logic [31:0] i_ar_addr;
  logic [2:0]  i_ar_prot;
  logic        i_ar_valid;
  logic        o_ar_ready;
  logic [31:0] o_r_data;
  logic [1:0]  o_r_resp;
  logic        o_r_valid;
  logic        i_r_ready;
  logic [31:0] o_paddr;
  logic        o_psel;
  logic        o_penable;
  logic        o_pwrite;
  logic [31:0] o_pwdata;
  logic [3:0]  o_pstrb;
  logic [2:0]  o_pprot;
  logic [31:0] i_prdata;
  logic        i_pready;
  logic        i_pslverr;

  adam_axil_apb_bridge #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .STRB_WIDTH(4),
    .TIMEOUT   (TO)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_pause_req(i_pause_req),
    .o_pause_ack(o_pause_ack),
    .i_aw_addr  (i_aw_addr),
    .i_aw_prot  (i_aw_prot),
    .i_aw_valid (i_aw_valid),
    .o_aw_ready (o_aw_ready),
    .i_w_data   (i_w_data),
    .i_w_strb   (i_w_strb),
    .i_w_valid  (i_w_valid),
    .o_w_ready  (o_w_ready),
    .o_b_resp   (o_b_resp),
    .o_b_valid  (o_b_valid),
    .i_b_ready  (i_b_ready),
    .i_ar_addr  (i_ar_addr),
    .i_ar_prot  (i_ar_prot),
    .i_ar_valid (i_ar_valid),
    .o_ar_ready (o_ar_ready),
    .o_r_data   (o_r_data),
    .o_r_resp   (o_r_resp),
    .o_r_valid  (o_r_valid),
    .i_r_ready  (i_r_ready),
    .o_paddr    (o_paddr),
    .o_psel     (o_psel),
    .o_penable  (o_penable),
    .o_pwrite   (o_pwrite),
    .o_pwdata   (o_pwdata),
    .o_pstrb    (o_pstrb),
    .o_pprot    (o_pprot),
    .i_prdata   (i_prdata),
    .i_pready   (i_pready),
    .i_pslverr  (i_pslverr)
  );

  int          n_chk;
  int          n_fail;
  bit          has_w;
  bit          has_r;
  req_t        pw;
  req_t        pr;
  bit          wturn;
  logic [31:0] last_wdata;
  req_t        q;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_req();
    i_aw_valid = has_w;
    i_w_valid  = has_w;
    i_aw_addr  = pw.addr;
    i_aw_prot  = pw.prot;
    i_w_data   = pw.data;
    i_w_strb   = pw.strb;
    i_ar_valid = has_r;
    i_ar_addr  = pr.addr;
    i_ar_prot  = pr.prot;
  endtask

  task automatic new_wr(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] p);
    pw    = '{wr: 1'b1, addr: a, data: d, strb: s, prot: p};
    has_w = 1'b1;
  endtask

  task automatic new_rd(input logic [31:0] a, input logic [2:0] p);
    pr    = '{wr: 1'b0, addr: a, data: '0, strb: '0, prot: p};
    has_r = 1'b1;
  endtask

  // Present pending requests, expect the arbitration winner, return it.
  task automatic issue(output req_t qo);
    bit tw;
    drive_req();
    tw = has_w && (!has_r || wturn);
    if (has_w && has_r) wturn = !wturn;
    #1;
    check("aw_ready", o_aw_ready, tw);
    check("w_ready", o_w_ready, tw);
    check("ar_ready", o_ar_ready, !tw && has_r);
    @(negedge i_clk);
    if (tw) begin
      qo         = pw;
      has_w      = 1'b0;
      last_wdata = pw.data;
    end else begin
      qo    = pr;
      has_r = 1'b0;
    end
    drive_req();
    #1;
  endtask

  // Act as the APB completer and AXI response sink for one transfer.
  task automatic serve(input req_t r, input int waits, input bit perr,
                       input logic [31:0] prd, input int rdly, input bit pz);
    bit          to;
    int          n;
    logic [31:0] ed;
    to = (waits >= TO);
    ed = to ? 32'h0 : prd;
    check("setup_psel", o_psel, 1);
    check("setup_pen", o_penable, 0);
    check("paddr", o_paddr, r.addr);
    check("pwrite", o_pwrite, r.wr);
    check("pprot", o_pprot, r.prot);
    check("pstrb", o_pstrb, r.wr ? r.strb : 4'h0);
    check("pwdata", o_pwdata, r.wr ? r.data : last_wdata);
    n = to ? TO : waits + 1;
    for (int c = 0; c < n; c++) begin
      @(negedge i_clk);
      if (pz && c == 0) i_pause_req = 1'b1;
      i_pready  = (c == waits);
      i_prdata  = (c == waits) ? prd : $urandom;
      i_pslverr = (c == waits) ? perr : 1'($urandom_range(0, 1));
      #1;
      check("acc_psel", o_psel, 1);
      check("acc_pen", o_penable, 1);
      check("acc_noresp", o_b_valid | o_r_valid, 0);
    end
    @(negedge i_clk);
    i_pready  = 1'b0;
    i_pslverr = 1'b0;
    for (int d = 0; d <= rdly; d++) begin
      if (d > 0) @(negedge i_clk);
      i_b_ready = r.wr && (d == rdly);
      i_r_ready = !r.wr && (d == rdly);
      #1;
      check("resp_psel", o_psel, 0);
      check("b_valid", o_b_valid, r.wr);
      check("r_valid", o_r_valid, !r.wr);
      if (r.wr) begin
        check("b_resp", o_b_resp, (to || perr) ? 2'b10 : 2'b00);
      end else begin
        check("r_resp", o_r_resp, (to || perr) ? 2'b10 : 2'b00);
        check("r_data", o_r_data, ed);
      end
    end
    @(negedge i_clk);
    i_b_ready = 1'b0;
    i_r_ready = 1'b0;
    #1;
    check("post_valid", o_b_valid | o_r_valid, 0);
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    has_w       = 1'b0;
    has_r       = 1'b0;
    pw          = '0;
    pr          = '0;
    wturn       = 1'b1;
    last_wdata  = '0;
    i_rst       = 1'b1;
    i_pause_req = 1'b0;
    i_b_ready   = 1'b0;
    i_r_ready   = 1'b0;
    i_prdata    = '0;
    i_pready    = 1'b0;
    i_pslverr   = 1'b0;
    drive_req();
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("rst_psel", o_psel, 0);
    check("rst_pen", o_penable, 0);
    check("rst_pwrite", o_pwrite, 0);
    check("rst_bv", o_b_valid, 0);
    check("rst_rv", o_r_valid, 0);
    check("rst_ack", o_pause_ack, 0);
    check("rst_paddr", o_paddr, 0);
    check("rst_pwdata", o_pwdata, 0);
    check("rst_pstrb", o_pstrb, 0);
    check("rst_pprot", o_pprot, 0);
    check("rst_rdata", o_r_data, 0);
    check("rst_bresp", o_b_resp, 0);
    check("rst_rresp", o_r_resp, 0);

    // AW without W must never be accepted
    i_aw_valid = 1'b1;
    i_aw_addr  = 32'h1000;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("aw_alone", o_aw_ready | o_w_ready, 0);
      @(negedge i_clk);
    end
    new_wr(32'h1000, 32'hDEADBEEF, 4'hF, 3'd0);
    issue(q);
    serve(q, 0, 1'b0, 32'h0, 0, 1'b0);

    new_rd(32'h2004, 3'd1);
    issue(q);
    serve(q, 3, 1'b0, 32'h12345678, 1, 1'b0);

    new_wr(32'h3000, 32'hA5A5_0F0F, 4'h3, 3'd2);
    issue(q);
    serve(q, 0, 1'b1, 32'h0, 0, 1'b0);

    new_rd(32'h3004, 3'd0);
    issue(q);
    serve(q, 20, 1'b0, 32'hFFFF_FFFF, 0, 1'b0);

    // competing AW/W and AR: alternating order starting with write
    for (int i = 0; i < 4; i++) begin
      if (!has_w) new_wr($urandom & 32'hFFFC, $urandom, 4'($urandom), 3'd0);
      if (!has_r) new_rd($urandom & 32'hFFFC, 3'd0);
      issue(q);
      check("arb_order", q.wr, (i % 2 == 0));
      serve(q, i, 1'b0, $urandom, 0, 1'b0);
    end

    // pause raised during ACCESS, honoured only after the B handshake
    issue(q);
    serve(q, 2, 1'b0, 32'h0, 0, 1'b1);
    new_rd(32'h4008, 3'd5);
    drive_req();
    #1;
    check("pz_idle_ack", o_pause_ack, 0);
    check("pz_idle_ar", o_ar_ready, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      #1;
      check("pz_ack", o_pause_ack, 1);
      check("pz_ready", o_ar_ready | o_aw_ready | o_w_ready, 0);
      check("pz_psel", o_psel, 0);
    end
    @(negedge i_clk);
    i_pause_req = 1'b0;
    #1;
    check("pz_rel_ack", o_pause_ack, 1);
    @(negedge i_clk);
    #1;
    check("pz_off_ack", o_pause_ack, 0);
    check("pz_off_ar", o_ar_ready, 1);
    issue(q);
    check("pz_q_read", q.wr, 0);
    serve(q, 1, 1'b0, 32'hCAFE_F00D, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      if (!has_w && $urandom_range(0, 1) == 1)
        new_wr($urandom & ~32'h3, $urandom, 4'($urandom), 3'($urandom));
      if (!has_r && $urandom_range(0, 1) == 1)
        new_rd($urandom & ~32'h3, 3'($urandom));
      if (!has_w && !has_r)
        new_wr($urandom & ~32'h3, $urandom, 4'($urandom), 3'($urandom));
      issue(q);
      serve(q, $urandom_range(0, 10), ($urandom_range(0, 3) == 0),
            $urandom, $urandom_range(0, 2), 1'b0);
    end
    while (has_w || has_r) begin
      issue(q);
      serve(q, 1, 1'b0, $urandom, 0, 1'b0);
    end

    // reset in ACCESS aborts without a late response
    new_wr(32'h5000, 32'h1234_5678, 4'hF, 3'd0);
    issue(q);
    @(negedge i_clk);
    #1;
    check("ra_acc_pen", o_penable, 1);
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    wturn      = 1'b1;
    last_wdata = '0;
    check("ra_psel", o_psel, 0);
    check("ra_pen", o_penable, 0);
    check("ra_pwdata", o_pwdata, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      #1;
      check("ra_no_resp", o_b_valid | o_r_valid, 0);
    end
    new_wr(32'h6000, 32'h0BAD_F00D, 4'h5, 3'd3);
    new_rd(32'h6004, 3'd4);
    issue(q);
    check("ra_prio_wr", q.wr, 1);
    serve(q, 0, 1'b0, 32'h0, 0, 1'b0);
    issue(q);
    serve(q, 0, 1'b0, 32'h7777_8888, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
